// File: rtl/toll_pkg.sv
// Shared toll-plaza definitions: E-pass result codes and lane
// arbiter state encodings, also used by the gate controller.
package toll_pkg;

  localparam logic [1:0] EPASS_PENDING = 2'b00;
  localparam logic [1:0] EPASS_INVALID = 2'b01;
  localparam logic [1:0] EPASS_VALID   = 2'b10;
  localparam logic [1:0] EPASS_ERR     = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  // A lane must only ever see VALID or INVALID.
  function automatic logic [1:0] lane_code(
    input logic [1:0] code
  );
    logic [1:0] r;
    r = EPASS_INVALID;
    if (code == EPASS_VALID) r = EPASS_VALID;
    return r;
  endfunction

  function automatic logic code_bad(
    input logic [1:0] code
  );
    return (code == EPASS_PENDING) ||
           (code == EPASS_ERR);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request searching upward
// from ptr+1 with wraparound.
module rr_pick #(
  parameter  int N  = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] grant,
  output logic          any_valid
);

  always_comb begin
    int idx;
    grant     = '0;
    any_valid = 1'b0;
    idx       = 0;
    // Walk from farthest to nearest so the nearest hit wins.
    for (int i = N; i >= 1; i--) begin
      idx = (int'(ptr) + i) % N;
      if (req[idx]) begin
        grant     = PW'(idx);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/epass_lane_arbiter.sv
// Shares one E-pass tag validator between several toll lanes
// with round-robin grant, req/ack handshake and timeout.
module epass_lane_arbiter
  import toll_pkg::*;
#(
  parameter  int NUM_LANES = 4,
  parameter  int TAG_W     = 16,
  parameter  int TIMEOUT   = 255,
  localparam int GW        = $clog2(NUM_LANES),
  localparam int CW        = $clog2(TIMEOUT + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_LANES-1:0]       lane_req,
  input  logic [NUM_LANES*TAG_W-1:0] lane_tag,
  output logic [NUM_LANES-1:0]       lane_done,
  output logic [1:0]                 lane_result,
  output logic                       val_req,
  output logic [TAG_W-1:0]           val_tag,
  input  logic                       val_ack,
  input  logic [1:0]                 val_result,
  output logic [GW-1:0]              grant_id,
  output logic                       busy,
  output logic                       timeout_err,
  output logic                       proto_err
);

  arb_state_e           state_q, state_d;
  logic [GW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]        wait_cnt_q, wait_cnt_d;
  logic [NUM_LANES-1:0] served_q, served_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic                 val_req_q, val_req_d;
  logic [1:0]           result_q, result_d;
  logic                 tout_q, tout_d;
  logic                 proto_q, proto_d;

  logic [NUM_LANES-1:0] eligible;
  logic [GW-1:0]        pick_idx;
  logic                 pick_any;

  assign eligible = lane_req & ~served_q;

  rr_pick #(.N(NUM_LANES)) u_pick (
    .req       (eligible),
    .ptr       (rr_ptr_q),
    .grant     (pick_idx),
    .any_valid (pick_any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= GW'(NUM_LANES - 1);
      wait_cnt_q <= '0;
      served_q   <= '0;
      grant_q    <= '0;
      tag_q      <= '0;
      val_req_q  <= 1'b0;
      result_q   <= 2'b00;
      tout_q     <= 1'b0;
      proto_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      wait_cnt_q <= wait_cnt_d;
      served_q   <= served_d;
      grant_q    <= grant_d;
      tag_q      <= tag_d;
      val_req_q  <= val_req_d;
      result_q   <= result_d;
      tout_q     <= tout_d;
      proto_q    <= proto_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    wait_cnt_d = wait_cnt_q;
    served_d   = served_q;
    grant_d    = grant_q;
    tag_d      = tag_q;
    val_req_d  = val_req_q;
    result_d   = result_q;
    tout_d     = 1'b0;
    proto_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        served_d = '0;
        if (pick_any) begin
          grant_d    = pick_idx;
          tag_d      = lane_tag[int'(pick_idx)*TAG_W +: TAG_W];
          val_req_d  = 1'b1;
          rr_ptr_d   = pick_idx;
          wait_cnt_d = '0;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        // Ack beats a simultaneous timeout.
        if (val_ack) begin
          result_d  = lane_code(val_result);
          proto_d   = code_bad(val_result);
          val_req_d = 1'b0;
          state_d   = RESP;
        end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
          result_d  = EPASS_INVALID;
          tout_d    = 1'b1;
          val_req_d = 1'b0;
          state_d   = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      RESP: begin
        served_d           = '0;
        served_d[grant_q]  = 1'b1;
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lane_done   = '0;
    lane_result = 2'b00;
    if (state_q == RESP) begin
      lane_done[grant_q] = 1'b1;
      lane_result        = result_q;
    end
  end

  assign val_req     = val_req_q;
  assign val_tag     = tag_q;
  assign grant_id    = grant_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = tout_q;
  assign proto_err   = proto_q;

endmodule

// File: tb/tb_epass_lane_arbiter.sv
// Directed bench for epass_lane_arbiter: vector table plus
// round-robin, ignored-ack and mid-WAIT reset sequences.
module tb_epass_lane_arbiter;

  localparam int N  = 4;
  localparam int TW = 16;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  lane_req;
  logic [N*TW-1:0] lane_tag;
  logic [N-1:0]  lane_done;
  logic [1:0]    lane_result;
  logic          val_req;
  logic [TW-1:0] val_tag;
  logic          val_ack;
  logic [1:0]    val_result;
  logic [1:0]    grant_id;
  logic          busy;
  logic          timeout_err;
  logic          proto_err;

  int n_cmp  = 0;
  int n_fail = 0;

  epass_lane_arbiter #(
    .NUM_LANES (N),
    .TAG_W     (TW),
    .TIMEOUT   (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .lane_req    (lane_req),
    .lane_tag    (lane_tag),
    .lane_done   (lane_done),
    .lane_result (lane_result),
    .val_req     (val_req),
    .val_tag     (val_tag),
    .val_ack     (val_ack),
    .val_result  (val_result),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err),
    .proto_err   (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    int          dly;
    logic [1:0]  vres;
    bit          drop;
    logic [1:0]  g;
    logic [15:0] tag;
    int          vc;
    logic [3:0]  dn;
    logic [1:0]  rs;
    logic        te;
    logic        pe;
  } vec_t;

  vec_t vt[8];

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic all_zero(input string name);
    check(name,
      {lane_done, lane_result, val_req, val_tag,
       grant_id, busy, timeout_err, proto_err}, 64'd0);
  endtask

  task automatic do_txn(
    input  int          dly,
    input  logic [1:0]  vres,
    input  bit          drop,
    output logic [1:0]  g,
    output logic [15:0] tg,
    output int          vc,
    output logic [3:0]  dn,
    output logic [1:0]  rs,
    output logic        te,
    output logic        pe
  );
    int w;
    w = 0;
    while (!val_req && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("val_req_rise", val_req, 1);
    g  = grant_id;
    tg = val_tag;
    vc = 0;
    while (val_req && vc < 40) begin
      val_ack    = (vc == dly);
      val_result = vres;
      if (drop && vc == 1) lane_req = '0;
      @(negedge clk);
      vc++;
    end
    val_ack    = 1'b0;
    val_result = 2'b00;
    dn = lane_done;
    rs = lane_result;
    te = timeout_err;
    pe = proto_err;
  endtask

  // Drop the served lane, step into IDLE, confirm pulses ended.
  task automatic finish_txn(input logic [3:0] dn);
    lane_req = lane_req & ~dn;
    @(negedge clk);
    check("pulse_end",
      {lane_done, timeout_err, proto_err}, 0);
  endtask

  initial begin
    logic [1:0]  g, pg;
    logic [15:0] tg;
    int          vc;
    logic [3:0]  dn;
    logic [1:0]  rs;
    logic        te, pe;

    vt[0] = '{4'b0100, 3, 2'b10, 0,
              2, 16'h1234, 4, 4'b0100, 2'b10, 0, 0};
    vt[1] = '{4'b0010, -1, 2'b10, 0,
              1, 16'hB1B1, 8, 4'b0010, 2'b01, 1, 0};
    vt[2] = '{4'b1000, 1, 2'b11, 0,
              3, 16'hD3D3, 2, 4'b1000, 2'b01, 0, 1};
    vt[3] = '{4'b0010, 7, 2'b10, 1,
              1, 16'hB1B1, 8, 4'b0010, 2'b10, 0, 0};
    vt[4] = '{4'b0001, 0, 2'b00, 0,
              0, 16'hA0A0, 1, 4'b0001, 2'b01, 0, 1};
    vt[5] = '{4'b0001, 2, 2'b01, 0,
              0, 16'hA0A0, 3, 4'b0001, 2'b01, 0, 0};
    vt[6] = '{4'b0110, 0, 2'b10, 0,
              1, 16'hB1B1, 1, 4'b0010, 2'b10, 0, 0};
    vt[7] = '{4'b0101, 0, 2'b10, 0,
              2, 16'h1234, 1, 4'b0100, 2'b10, 0, 0};

    reset      = 1'b1;
    lane_req   = '0;
    lane_tag   = {16'hD3D3, 16'h1234, 16'hB1B1, 16'hA0A0};
    val_ack    = 1'b0;
    val_result = 2'b00;
    repeat (3) @(negedge clk);
    all_zero("reset_state");
    reset = 1'b0;
    @(negedge clk);

    // Round robin with all lanes requesting, two rounds.
    pg = 2'd3;
    for (int r = 0; r < 2; r++) begin
      lane_req = 4'hF;
      for (int k = 0; k < 4; k++) begin
        do_txn(0, 2'b10, 0, g, tg, vc, dn, rs, te, pe);
        check($sformatf("rr_grant_%0d_%0d", r, k), g, k);
        check("rr_not_repeat", (g != pg), 1);
        check("rr_done", dn, 4'b0001 << k);
        pg = g;
        finish_txn(dn);
      end
    end

    foreach (vt[i]) begin
      lane_req = vt[i].req;
      do_txn(vt[i].dly, vt[i].vres, vt[i].drop,
             g, tg, vc, dn, rs, te, pe);
      check($sformatf("v%0d_grant", i), g, vt[i].g);
      check($sformatf("v%0d_tag", i), tg, vt[i].tag);
      check($sformatf("v%0d_vcyc", i), vc, vt[i].vc);
      check($sformatf("v%0d_done", i), dn, vt[i].dn);
      check($sformatf("v%0d_res", i), rs, vt[i].rs);
      check($sformatf("v%0d_tout", i), te, vt[i].te);
      check($sformatf("v%0d_proto", i), pe, vt[i].pe);
      lane_req = '0;
      @(negedge clk);
      check($sformatf("v%0d_pulse", i),
        {lane_done, timeout_err, proto_err, busy}, 0);
    end

    // Ack with no request outstanding must be ignored.
    val_ack    = 1'b1;
    val_result = 2'b10;
    @(negedge clk);
    val_ack = 1'b0;
    @(negedge clk);
    check("stray_ack",
      {lane_done, busy, val_req, proto_err}, 0);

    // Reset two cycles into WAIT.
    lane_req = 4'b0100;
    begin
      int w;
      w = 0;
      while (!val_req && w < 20) begin
        @(negedge clk);
        w++;
      end
    end
    check("rst_wait_req", val_req, 1);
    @(negedge clk);
    reset    = 1'b1;
    lane_req = '0;
    @(negedge clk);
    all_zero("rst_mid_wait");
    reset    = 1'b0;
    lane_req = 4'b1001;
    do_txn(0, 2'b10, 0, g, tg, vc, dn, rs, te, pe);
    check("post_rst_grant0", g, 0);
    check("post_rst_done0", dn, 4'b0001);
    finish_txn(dn);
    do_txn(0, 2'b10, 0, g, tg, vc, dn, rs, te, pe);
    check("post_rst_grant3", g, 3);
    check("post_rst_tag3", tg, 16'hD3D3);
    finish_txn(dn);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
